// File: rtl/control_seq.sv
// control_seq: registered micro-sequencer that steps the datapath through one STATE_* code per
// clock, with memory wait states, a bus timeout, conditional jump, store and a resumable halt.
`ifndef STATE_FETCH_PC
`define STATE_FETCH_PC   4'd0
`endif
`ifndef STATE_FETCH_INST
`define STATE_FETCH_INST 4'd1
`endif
`ifndef STATE_FETCH_ARG
`define STATE_FETCH_ARG  4'd2
`endif
`ifndef STATE_LOAD_Z
`define STATE_LOAD_Z     4'd3
`endif
`ifndef STATE_RAM_A
`define STATE_RAM_A      4'd4
`endif
`ifndef STATE_RAM_B
`define STATE_RAM_B      4'd5
`endif
`ifndef STATE_ALU
`define STATE_ALU        4'd6
`endif
`ifndef STATE_JUMP_Z
`define STATE_JUMP_Z     4'd7
`endif
`ifndef STATE_OUT_A
`define STATE_OUT_A      4'd8
`endif
`ifndef STATE_HALT
`define STATE_HALT       4'd9
`endif
`ifndef STATE_NEXT
`define STATE_NEXT       4'd10
`endif
`ifndef STATE_DECODE
`define STATE_DECODE     4'd11
`endif
`ifndef STATE_SKIP
`define STATE_SKIP       4'd12
`endif
`ifndef STATE_STORE_A
`define STATE_STORE_A    4'd13
`endif
`ifndef OP_LDA
`define OP_LDA 1
`endif
`ifndef OP_ADD
`define OP_ADD 2
`endif
`ifndef OP_SUB
`define OP_SUB 3
`endif
`ifndef OP_STA
`define OP_STA 4
`endif
`ifndef OP_JMP
`define OP_JMP 5
`endif
`ifndef OP_JEZ
`define OP_JEZ 6
`endif
`ifndef OP_OUT
`define OP_OUT 7
`endif
`ifndef OP_HLT
`define OP_HLT 15
`endif

module control_seq #(
    parameter int OPCODE_W = 4,
    parameter int CYCLE_W  = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                zero_flag_i,
    input  logic                mem_ready_i,
    input  logic                resume_i,
    output logic [3:0]          state_o,
    output logic [CYCLE_W-1:0]  cycle_o,
    output logic                halted_o,
    output logic                inst_done_o,
    output logic                illegal_o,
    output logic                bus_error_o
);
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

    localparam logic [OPCODE_W-1:0] OPC_LDA = OPCODE_W'(`OP_LDA);
    localparam logic [OPCODE_W-1:0] OPC_ADD = OPCODE_W'(`OP_ADD);
    localparam logic [OPCODE_W-1:0] OPC_SUB = OPCODE_W'(`OP_SUB);
    localparam logic [OPCODE_W-1:0] OPC_STA = OPCODE_W'(`OP_STA);
    localparam logic [OPCODE_W-1:0] OPC_JMP = OPCODE_W'(`OP_JMP);
    localparam logic [OPCODE_W-1:0] OPC_JEZ = OPCODE_W'(`OP_JEZ);
    localparam logic [OPCODE_W-1:0] OPC_OUT = OPCODE_W'(`OP_OUT);
    localparam logic [OPCODE_W-1:0] OPC_HLT = OPCODE_W'(`OP_HLT);

    typedef enum logic [3:0] {
        ST_FETCH_PC   = `STATE_FETCH_PC,
        ST_FETCH_INST = `STATE_FETCH_INST,
        ST_FETCH_ARG  = `STATE_FETCH_ARG,
        ST_LOAD_Z     = `STATE_LOAD_Z,
        ST_RAM_A      = `STATE_RAM_A,
        ST_RAM_B      = `STATE_RAM_B,
        ST_ALU        = `STATE_ALU,
        ST_JUMP_Z     = `STATE_JUMP_Z,
        ST_OUT_A      = `STATE_OUT_A,
        ST_HALT       = `STATE_HALT,
        ST_NEXT       = `STATE_NEXT,
        ST_DECODE     = `STATE_DECODE,
        ST_SKIP       = `STATE_SKIP,
        ST_STORE_A    = `STATE_STORE_A
    } state_t;

    state_t                state_q, state_d;
    logic [CYCLE_W-1:0]    cycle_q, cycle_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [OPCODE_W-1:0]   op_q;
    logic                  z_q;
    logic                  halted_q, done_q, illegal_q, bus_error_q;
    logic                  is_mem, timeout, take_jump;

    assign is_mem = (state_q == ST_FETCH_INST) || (state_q == ST_FETCH_ARG) ||
                    (state_q == ST_RAM_A) || (state_q == ST_RAM_B) ||
                    (state_q == ST_STORE_A);

    // Second FETCH_PC (cycle 3) only exists for LDA/STA/ADD/SUB/JMP and taken JEZ.
    assign take_jump = (op_q == OPC_JMP) || ((op_q == OPC_JEZ) && z_q);

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        wait_d  = '0;
        timeout = 1'b0;
        if (is_mem && !mem_ready_i) begin
            if ((MAX_WAIT != 0) && (wait_q == WAIT_LIM)) begin
                state_d = ST_HALT;
                timeout = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end else begin
            case (state_q)
                ST_FETCH_PC:   state_d = (cycle_q == '0) ? ST_FETCH_INST :
                                         (take_jump ? ST_JUMP_Z : ST_FETCH_ARG);
                ST_FETCH_INST: state_d = ST_DECODE;
                ST_DECODE: begin
                    case (opcode_i)
                        OPC_LDA, OPC_STA, OPC_ADD, OPC_SUB, OPC_JMP: state_d = ST_FETCH_PC;
                        OPC_JEZ: state_d = zero_flag_i ? ST_FETCH_PC : ST_SKIP;
                        OPC_OUT: state_d = ST_OUT_A;
                        OPC_HLT: state_d = ST_HALT;
                        default: state_d = ST_NEXT;
                    endcase
                end
                ST_FETCH_ARG:  state_d = ST_LOAD_Z;
                ST_LOAD_Z:     state_d = (op_q == OPC_STA) ? ST_STORE_A :
                                         ((op_q == OPC_LDA) ? ST_RAM_A : ST_RAM_B);
                ST_RAM_B:      state_d = ST_ALU;
                ST_RAM_A, ST_STORE_A, ST_ALU, ST_JUMP_Z, ST_SKIP, ST_OUT_A:
                               state_d = ST_NEXT;
                ST_HALT:       state_d = (resume_i && !bus_error_q) ? ST_NEXT : ST_HALT;
                ST_NEXT:       state_d = ST_FETCH_PC;
                default:       state_d = ST_FETCH_PC;
            endcase
            if (state_d != state_q) begin
                cycle_d = (state_q == ST_NEXT) ? '0 : cycle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FETCH_PC;
            cycle_q     <= '0;
            wait_q      <= '0;
            op_q        <= '0;
            z_q         <= 1'b0;
            halted_q    <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            wait_q    <= wait_d;
            halted_q  <= (state_d == ST_HALT);
            done_q    <= (state_d == ST_NEXT);
            // Only an undefined opcode goes straight from DECODE to NEXT.
            illegal_q <= (state_q == ST_DECODE) && (state_d == ST_NEXT);
            if (timeout) begin
                bus_error_q <= 1'b1;
            end
            if (state_q == ST_DECODE) begin
                op_q <= opcode_i;
                z_q  <= zero_flag_i;
            end
        end
    end

    assign state_o     = state_q;
    assign cycle_o     = cycle_q;
    assign halted_o    = halted_q;
    assign inst_done_o = done_q;
    assign illegal_o   = illegal_q;
    assign bus_error_o = bus_error_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: expected state/cycle/flags are queued as each clock is
// driven and checked one clock later against the DUT outputs.
module tb_control_seq;
    localparam int MAX_WAIT = 15;

    localparam logic [3:0] S_FETCH_PC   = 4'd0;
    localparam logic [3:0] S_FETCH_INST = 4'd1;
    localparam logic [3:0] S_FETCH_ARG  = 4'd2;
    localparam logic [3:0] S_LOAD_Z     = 4'd3;
    localparam logic [3:0] S_RAM_A      = 4'd4;
    localparam logic [3:0] S_RAM_B      = 4'd5;
    localparam logic [3:0] S_ALU        = 4'd6;
    localparam logic [3:0] S_JUMP_Z     = 4'd7;
    localparam logic [3:0] S_OUT_A      = 4'd8;
    localparam logic [3:0] S_HALT       = 4'd9;
    localparam logic [3:0] S_NEXT       = 4'd10;
    localparam logic [3:0] S_DECODE     = 4'd11;
    localparam logic [3:0] S_SKIP       = 4'd12;
    localparam logic [3:0] S_STORE_A    = 4'd13;
    localparam logic [3:0] S_NONE       = 4'd15;

    localparam logic [3:0] O_LDA = 4'h1;
    localparam logic [3:0] O_ADD = 4'h2;
    localparam logic [3:0] O_SUB = 4'h3;
    localparam logic [3:0] O_STA = 4'h4;
    localparam logic [3:0] O_JMP = 4'h5;
    localparam logic [3:0] O_JEZ = 4'h6;
    localparam logic [3:0] O_OUT = 4'h7;
    localparam logic [3:0] O_HLT = 4'hF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] opcode_i = '0;
    logic       zero_flag_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       resume_i = 1'b0;
    logic [3:0] state_o;
    logic [3:0] cycle_o;
    logic       halted_o, inst_done_o, illegal_o, bus_error_o;

    control_seq #(.OPCODE_W(4), .CYCLE_W(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode_i    (opcode_i),
        .zero_flag_i (zero_flag_i),
        .mem_ready_i (mem_ready_i),
        .resume_i    (resume_i),
        .state_o     (state_o),
        .cycle_o     (cycle_o),
        .halted_o    (halted_o),
        .inst_done_o (inst_done_o),
        .illegal_o   (illegal_o),
        .bus_error_o (bus_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] cyc;
        logic       ill;
        logic       berr;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] path[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [3:0] st, input int cyc, input logic ill, input logic berr);
        exp_t e;
        e.st   = st;
        e.cyc  = 4'(cyc);
        e.ill  = ill;
        e.berr = berr;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, ".state"},  32'(state_o),     32'(e.st));
        check_val({tag, ".cycle"},  32'(cycle_o),     32'(e.cyc));
        check_val({tag, ".halted"}, 32'(halted_o),    32'(e.st == S_HALT));
        check_val({tag, ".done"},   32'(inst_done_o), 32'(e.st == S_NEXT));
        check_val({tag, ".illegal"},32'(illegal_o),   32'(e.ill));
        check_val({tag, ".buserr"}, 32'(bus_error_o), 32'(e.berr));
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] st);
        return (st == S_FETCH_INST) || (st == S_FETCH_ARG) || (st == S_RAM_A) ||
               (st == S_RAM_B) || (st == S_STORE_A);
    endfunction

    function automatic bit is_def(input logic [3:0] op);
        return (op inside {O_LDA, O_ADD, O_SUB, O_STA, O_JMP, O_JEZ, O_OUT, O_HLT});
    endfunction

    // Async reset asserted away from the edge; checked immediately, released at a falling edge.
    task automatic apply_reset(input string tag);
        exp_t e;
        reset_n = 1'b0;
        #1;
        e.st = S_FETCH_PC; e.cyc = 4'd0; e.ill = 1'b0; e.berr = 1'b0;
        check_outputs({tag, ".in_reset"}, e);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_outputs({tag, ".released"}, e);
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input logic z,
                             input logic [3:0] stall_st, input int stall_n,
                             input int halt_hold, input int abort_at);
        int clocks = 0;
        path.delete();
        path.push_back(S_FETCH_PC); path.push_back(S_FETCH_INST); path.push_back(S_DECODE);
        case (op)
            O_LDA: begin path.push_back(S_FETCH_PC); path.push_back(S_FETCH_ARG);
                         path.push_back(S_LOAD_Z); path.push_back(S_RAM_A); end
            O_STA: begin path.push_back(S_FETCH_PC); path.push_back(S_FETCH_ARG);
                         path.push_back(S_LOAD_Z); path.push_back(S_STORE_A); end
            O_ADD, O_SUB: begin path.push_back(S_FETCH_PC); path.push_back(S_FETCH_ARG);
                         path.push_back(S_LOAD_Z); path.push_back(S_RAM_B);
                         path.push_back(S_ALU); end
            O_JMP: begin path.push_back(S_FETCH_PC); path.push_back(S_JUMP_Z); end
            O_JEZ: begin
                if (z) begin path.push_back(S_FETCH_PC); path.push_back(S_JUMP_Z); end
                else   path.push_back(S_SKIP);
            end
            O_OUT: path.push_back(S_OUT_A);
            O_HLT: path.push_back(S_HALT);
            default: ;
        endcase
        path.push_back(S_NEXT);

        for (int i = 0; i < path.size(); i++) begin
            logic [3:0] cur;
            logic [3:0] nxt;
            int         ncyc;
            int         holds;
            if (i == abort_at) begin
                $display("txn %-8s op=%h aborted at cycle %0d after %0d clocks", name, op, i, clocks);
                return;
            end
            cur = path[i];
            if (cur == S_NEXT) begin
                nxt = S_FETCH_PC; ncyc = 0;
            end else begin
                nxt = path[i+1]; ncyc = i + 1;
            end
            holds = 0;
            if (cur == stall_st) holds = stall_n;
            if (cur == S_HALT)   holds = halt_hold;
            for (int h = 0; h <= holds; h++) begin
                bit last;
                last = (h == holds);
                // Past DECODE the opcode and flag are scrambled; the DUT must ignore them.
                opcode_i    = (i <= 2) ? op : (op ^ 4'h5);
                zero_flag_i = (i <= 2) ? z : ~z;
                mem_ready_i = is_mem(cur) ? last : 1'($urandom_range(0, 1));
                resume_i    = (cur == S_HALT) ? last : 1'($urandom_range(0, 1));
                if (last) push_exp(nxt, ncyc, (nxt == S_NEXT) && !is_def(op), 1'b0);
                else      push_exp(cur, i, 1'b0, 1'b0);
                step(name);
                clocks++;
            end
        end
        $display("txn %-8s op=%h z=%0d stall=%0d halt=%0d clocks=%0d", name, op, z, stall_n,
                 halt_hold, clocks);
    endtask

    task automatic run_timeout();
        opcode_i = O_LDA; zero_flag_i = 1'b0; resume_i = 1'b0;
        mem_ready_i = 1'b1;
        push_exp(S_FETCH_INST, 1, 1'b0, 1'b0);
        step("tmo.enter");
        for (int k = 0; k <= MAX_WAIT; k++) begin
            mem_ready_i = 1'b0;
            if (k < MAX_WAIT) push_exp(S_FETCH_INST, 1, 1'b0, 1'b0);
            else              push_exp(S_HALT, 1, 1'b0, 1'b1);
            step("tmo.stall");
        end
        for (int k = 0; k < 3; k++) begin
            mem_ready_i = 1'b1; resume_i = 1'b1;
            push_exp(S_HALT, 1, 1'b0, 1'b1);
            step("tmo.resume_ignored");
        end
        resume_i = 1'b0;
        $display("txn timeout  FETCH_INST stalled %0d clocks, halted with bus error", MAX_WAIT + 1);
        apply_reset("tmo.reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        #12;
        apply_reset("reset");
        run_instr("lda",     O_LDA, 1'b0, S_NONE,       0,  0, -1);
        run_instr("sta",     O_STA, 1'b1, S_STORE_A,    2,  0, -1);
        run_instr("add",     O_ADD, 1'b0, S_RAM_B,      3,  0, -1);
        run_instr("sub_max", O_SUB, 1'b0, S_FETCH_ARG,  MAX_WAIT, 0, -1);
        run_instr("jmp",     O_JMP, 1'b0, S_NONE,       0,  0, -1);
        run_instr("jez_z1",  O_JEZ, 1'b1, S_NONE,       0,  0, -1);
        run_instr("jez_z0",  O_JEZ, 1'b0, S_NONE,       0,  0, -1);
        run_instr("out",     O_OUT, 1'b0, S_FETCH_INST, 1,  0, -1);
        run_instr("hlt",     O_HLT, 1'b0, S_NONE,       0, 10, -1);
        run_instr("ill_e",   4'hE,  1'b0, S_NONE,       0,  0, -1);
        run_instr("ill_0",   4'h0,  1'b1, S_NONE,       0,  0, -1);
        run_instr("add_rst", O_ADD, 1'b0, S_NONE,       0,  0,  5);
        apply_reset("mid_add");
        run_instr("lda2",    O_LDA, 1'b1, S_RAM_A,      4,  0, -1);
        run_timeout();
        run_instr("lda3",    O_LDA, 1'b0, S_NONE,       0,  0, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_seq.md
# control_seq

Registered micro-sequencer that replaces the combinational cycle/opcode decoder. It owns the instruction cycle counter and steps the datapath through one `STATE_*` code per clock. It also adds memory wait states with a timeout, conditional jump (JEZ), store (STA), resumable halt and illegal-opcode detection. It sits between the instruction register/flags and the datapath control-word decoder in the CPU top level.

## Interface
- `OPCODE_W`, 4: opcode width. `OP_*` macros are zero-extended to this width.
- `CYCLE_W`, 4: cycle counter width. Must be ≥ 4.
- `MAX_WAIT`, 15: maximum consecutive stall cycles on one memory state. 0 disables the timeout.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `opcode` input OPCODE_W: instruction register contents.
- `zero_flag` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `resume` input 1: leave HALT.
- `state` output 4: current `STATE_*` code, registered.
- `cycle` output CYCLE_W: index of the current state within the instruction.
- `halted` output 1: high while `state` is `STATE_HALT`.
- `inst_done` output 1: high while `state` is `STATE_NEXT`.
- `illegal` output 1: one-cycle pulse for an undefined opcode.
- `bus_error` output 1: sticky memory-timeout flag.

## Operation
- Encodings come from `parameters.v`.
  - New codes added there: `STATE_DECODE`, `STATE_SKIP`, `STATE_STORE_A`.
  - New opcodes added there: `OP_STA`, `OP_JEZ`, `OP_ADD`, `OP_SUB`.
- Common prefix: cycle 0 FETCH_PC, cycle 1 FETCH_INST*, cycle 2 DECODE.
- On the edge leaving DECODE, the block latches `opcode` into op_q and `zero_flag` into z_q. Later branching uses only op_q/z_q.
- Sequences from cycle 3 on:
  - LDA: FETCH_PC, FETCH_ARG*, LOAD_Z, RAM_A*, NEXT.
  - STA: FETCH_PC, FETCH_ARG*, LOAD_Z, STORE_A*, NEXT.
  - ADD/SUB: FETCH_PC, FETCH_ARG*, LOAD_Z, RAM_B*, ALU, NEXT.
  - JMP, and JEZ with z_q=1: FETCH_PC, JUMP_Z, NEXT.
  - JEZ with z_q=0: SKIP, NEXT. SKIP tells the datapath to increment PC past the argument.
  - OUT: OUT_A, NEXT.
  - HLT: HALT, NEXT.
  - Undefined opcode: NEXT. `illegal` pulses during that NEXT cycle.
- After NEXT the block returns to FETCH_PC with `cycle` = 0.
- `cycle` increments on every advance and holds during stall or HALT.
- Memory states (marked *): FETCH_INST, FETCH_ARG, RAM_A, RAM_B, STORE_A.
  - With `mem_ready`=0, the block holds state and cycle, and wait_cnt increments.
  - With `mem_ready`=1, the block advances and wait_cnt clears.
  - wait_cnt also clears on entry to each memory state.
- Timeout: if MAX_WAIT≠0 and wait_cnt = MAX_WAIT while `mem_ready`=0, the next state is HALT and `bus_error` sets. `cycle` holds.
- HALT:
  - Held until `resume`=1 and `bus_error`=0; then NEXT on the following cycle.
  - `resume` outside HALT is ignored.
  - With `bus_error`=1, only reset leaves HALT.

## Timing
- Reset (async assert, sync release): `state`=FETCH_PC, `cycle`=0, `halted`=0, `inst_done`=0, `illegal`=0, `bus_error`=0, op_q=0, z_q=0, wait_cnt=0.
- One state per clock with no stalls. Instruction length:
  - LDA/STA: 8 clocks.
  - ADD/SUB: 9 clocks.
  - JMP/taken JEZ: 6 clocks.
  - Untaken JEZ/OUT: 5 clocks.
  - Illegal: 4 clocks.
  - HLT: 5 clocks plus the halt duration.
- All outputs are registered and change only on `clk` rising edge or `reset_n` assertion.
- `mem_ready` is sampled only in memory states. A high value elsewhere has no effect.
- `mem_ready`=1 on the timeout cycle: the access completes normally and there is no error.
- `opcode`/`zero_flag` changes after DECODE do not affect the running instruction.
- Reset mid-instruction, mid-stall or mid-HALT returns to FETCH_PC at cycle 0 and clears `bus_error`.

## Test plan
- LDA with `mem_ready`=1 throughout: `state` sequence FETCH_PC, FETCH_INST, DECODE, FETCH_PC, FETCH_ARG, LOAD_Z, RAM_A, NEXT, FETCH_PC; `cycle` 0..7 then 0; `inst_done` high for exactly 1 clock.
- ADD with `mem_ready` low for 3 clocks in RAM_B: RAM_B held 4 clocks with `cycle`=6 held; ALU at `cycle` 7; no `bus_error`.
- JEZ with `zero_flag`=1 at DECODE, toggled to 0 afterwards: path is JUMP_Z. Repeat with `zero_flag`=0: path is SKIP, NEXT at `cycle` 3, 4.
- HLT: `halted`=1 from `cycle` 3; hold 10 clocks with `resume`=0, state unchanged; `resume`=1 pulse → NEXT next clock, then FETCH_PC.
- MAX_WAIT=15, `mem_ready`=0 in FETCH_INST for 16 clocks: HALT entered and `bus_error`=1; `resume` ignored; `reset_n` low → FETCH_PC, `bus_error`=0.
- Undefined opcode (e.g. 4'hE): DECODE → NEXT with `illegal` pulse 1 clock. Reset asserted mid-ADD at `cycle` 5: immediate FETCH_PC, `cycle`=0.
